// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/busy/done operand and result bundle for serial_subtractor (ovf port under SERIAL_SUB_OVERFLOW_EN)
interface serial_subtractor_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             ovf;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out, ovf
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out, ovf
  );
`else
  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
  );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first subtractor with one borrow flop; SERIAL_SUB_OVERFLOW_EN adds signed overflow flag ovf
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_subtractor_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] res;
  logic             borrow;
  logic             borrow_out_r;
  logic [CNT_W-1:0] cnt;
  logic             load;
  logic             step;
  logic             last;
  logic             x;
  logic             y;
  logic             d;
  logic             bout;

  assign x    = sh_a[0];
  assign y    = sh_b[0];
  assign d    = x ^ y ^ borrow;
  assign bout = (~x & y) | (~(x ^ y) & borrow);

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == LAST_CNT) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        // Reload here gives back-to-back operation with no idle gap.
        if (bus.start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sh_a         <= '0;
      sh_b         <= '0;
      res          <= '0;
      borrow       <= 1'b0;
      borrow_out_r <= 1'b0;
      cnt          <= '0;
    end else begin
      state <= state_next;
      // res is deliberately not cleared on load so the last result stays visible.
      if (load) begin
        sh_a   <= bus.a;
        sh_b   <= bus.b;
        borrow <= 1'b0;
        cnt    <= '0;
      end else if (step) begin
        res    <= {d, res[WIDTH-1:1]};
        sh_a   <= {1'b0, sh_a[WIDTH-1:1]};
        sh_b   <= {1'b0, sh_b[WIDTH-1:1]};
        borrow <= bout;
        cnt    <= cnt + 1'b1;
        if (last) begin
          borrow_out_r <= bout;
        end
      end
    end
  end

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic ovf_r;

  // On the final edge the borrow register holds the borrow into the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (step && last) begin
      ovf_r <= borrow ^ bout;
    end
  end

  assign bus.ovf = ovf_r;
`endif

  assign bus.busy       = (state == RUN);
  assign bus.done       = (state == DONE);
  assign bus.diff       = res;
  assign bus.borrow_out = borrow_out_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor with random operands and a plain-arithmetic reference
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct {
    int         cyc;
    logic [W:0] res;
    logic       ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;
  logic [W:0] last_res = '0;
  exp_t q[$];

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int acc);
    exp_t e;
    int   r;
    e.cyc = acc + W;
    e.res = {1'b0, a} - {1'b0, b};
    r     = int'($signed(a)) - int'($signed(b));
    e.ovf = (r > (2 ** (W - 1)) - 1) || (r < -(2 ** (W - 1)));
    return e;
  endfunction

  // Monitor: pops on every done pulse, and checks the held result when idle.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && !rst) begin
      if (bus.done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 64'(bus.done), 64'(0));
        end else begin
          e = q.pop_front();
          chk("result", 64'({bus.borrow_out, bus.diff}), 64'(e.res));
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
`ifdef SERIAL_SUB_OVERFLOW_EN
          chk("ovf", 64'(bus.ovf), 64'(e.ovf));
`endif
          last_res = e.res;
        end
      end else if (!bus.busy) begin
        chk("held_result", 64'({bus.borrow_out, bus.diff}), 64'(last_res));
      end
    end
  end

  // Called at a negedge; returns at the negedge of the first RUN cycle.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int gap,
                       input bit noise, input bit scored);
    int guard = 0;
    while (bus.busy === 1'b1 && guard < 50) begin
      if (noise) begin
        bus.start = 1'($urandom);
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("busy_timeout", 64'(bus.busy), 64'(0));
    bus.start = 1'b0;
    repeat (gap) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    if (scored) q.push_back(model(a, b, cyc));
    @(negedge clk);
    if (noise) begin
      bus.start = 1'b1;
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
    end else begin
      bus.start = 1'b0;
    end
  endtask

  logic [2*W-1:0] vec [9] = '{16'h3512, 16'h1235, 16'h0001, 16'hA5A5, 16'h8001,
                              16'h7FFF, 16'h0503, 16'hFF00, 16'h00FF};

  initial begin
    logic [2*W-1:0] v;
    int             guard;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_result", 64'({bus.borrow_out, bus.diff}), 64'(0));
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("rst_ovf", 64'(bus.ovf), 64'(0));
`endif
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    foreach (vec[i]) begin
      v = vec[i];
      do_op(v[2*W-1:W], v[W-1:0], 2, 1'b0, 1'b1);
    end

    // Start held high with changing operands mid-RUN: back-to-back, no queuing.
    for (int i = 0; i < 6; i++) do_op(W'($urandom), W'($urandom), 0, 1'b1, 1'b1);

    // Abort in the 4th RUN cycle, then recover.
    do_op(8'h3C, 8'h5A, 1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst      = 1'b1;
    last_res = '0;
    @(negedge clk);
    chk("abort_busy", 64'(bus.busy), 64'(0));
    chk("abort_done", 64'(bus.done), 64'(0));
    chk("abort_result", 64'({bus.borrow_out, bus.diff}), 64'(0));
    rst = 1'b0;
    do_op(8'h10, 8'h01, 1, 1'b0, 1'b1);

    // rst and start together: reset wins.
    repeat (W + 3) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h44;
    bus.b     = 8'h11;
    rst       = 1'b1;
    last_res  = '0;
    @(negedge clk);
    chk("rst_start_busy", 64'(bus.busy), 64'(0));
    chk("rst_start_result", 64'({bus.borrow_out, bus.diff}), 64'(0));
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 1000; i++)
      do_op(W'($urandom), W'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0), 1'b1);

    guard = 0;
    while (q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_queue", 64'(q.size()), 64'(0));
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
